// File: rtl/gigetx_pkg.sv
// gigetx_pkg: shared state encoding, header layout, limits and helpers for the TX FIFO reader.
package gigetx_pkg;
  typedef enum logic [2:0] {IDLE, HDR, WAIT, STREAM, DROP, IPG} state_t;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;
  localparam int MAX_LEN = 1518;
  localparam int IPG_CYCLES = 2;
  localparam int REM_W = 14;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
  } word_t;
  function automatic logic [7:0] be_mask(input logic [2:0] l);
    return l == 3'd0 ? 8'hFF : (8'h01 << l) - 8'h01;
  endfunction
  function automatic logic [REM_W-1:0] len2words(input logic [15:0] len);
    logic [16:0] s;
    s = {1'b0, len} + 17'd7;
    return s[16:3];
  endfunction
endpackage

// File: rtl/gigetx_skid2.sv
// gigetx_skid2: 2-entry output buffer between the FIFO read data and the tx valid/ready port.
module gigetx_skid2
  import gigetx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  word_t      din,
  output logic       valid,
  input  logic       ready,
  output word_t      dout,
  output logic [1:0] count
);
  word_t e0, e1;
  logic pop;
  assign valid = count != 2'd0;
  assign pop = valid && ready;
  assign dout = valid ? e0 : '0;
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) e0 <= e1;
      if (push && count - 2'(pop) == 2'd0) e0 <= din;
      else if (push) e1 <= din;
    end
endmodule

// File: rtl/gigetx_fifo_reader.sv
// gigetx_fifo_reader: pops length-prefixed frames from the TX frame FIFO and streams them to the MAC.
// Define GIGETX_IPG_EN to force IPG_CYCLES idle cycles after every frame.
module gigetx_fifo_reader
  import gigetx_pkg::*;
#(
  parameter int PTR = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic         fifo_rdreq,
  input  logic [63:0]  fifo_q,
  input  logic         fifo_empty,
  input  logic [PTR:0] fifo_usedw,
  output logic [63:0]  tx_data,
  output logic [7:0]   tx_be,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         frame_done,
  output logic         frame_err,
  output logic         busy
);
`ifdef GIGETX_IPG_EN
  localparam state_t AFTER_EOP = IPG;
`else
  localparam state_t AFTER_EOP = IDLE;
`endif
  state_t state, state_n;
  logic [REM_W-1:0] words, remaining;
  logic [2:0] len_lo;
  logic [1:0] count;
  logic [15:0] hdr_len;
  logic rd_q, first, acc, room, push, stream_pop, drop_pop;
  word_t din, dout;
  assign hdr_len = fifo_q[HDR_LEN_MSB:HDR_LEN_LSB];
  assign acc = tx_valid && tx_ready;
  // room counts the word already in flight from the FIFO and the slot freed by this cycle's accept
  assign room = {1'b0, count} + {2'b0, rd_q} - {2'b0, acc} < 3'd2;
  assign push = rd_q && state == STREAM;
  assign stream_pop = state == STREAM && remaining != '0 && room;
  assign drop_pop = state == DROP && remaining != '0 && !fifo_empty;
  assign fifo_rdreq = !reset && (stream_pop || drop_pop || (state == IDLE && !fifo_empty));
  assign din = '{data: fifo_q, be: remaining == '0 ? be_mask(len_lo) : 8'hFF, sop: first, eop: remaining == '0};
  assign {tx_data, tx_be, tx_sop, tx_eop} = dout;
  assign frame_done = acc && tx_eop;
  assign frame_err = state == HDR && (hdr_len == 16'd0 || hdr_len > 16'(MAX_LEN));
  assign busy = state != IDLE;
  gigetx_skid2 skid (
    .clk(clk), .rst(reset), .push(push), .din(din),
    .valid(tx_valid), .ready(tx_ready), .dout(dout), .count(count)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = fifo_empty ? IDLE : HDR;
      HDR:      state_n = hdr_len == 16'd0 ? IDLE : frame_err ? DROP : WAIT;
      WAIT:     state_n = 32'(fifo_usedw) >= 32'(words) ? STREAM : WAIT;
      STREAM:   state_n = frame_done ? AFTER_EOP : STREAM;
      DROP, IPG: state_n = remaining == '0 ? IDLE : state;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rd_q <= 1'b0;
      first <= 1'b0;
      len_lo <= 3'd0;
      words <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      rd_q <= fifo_rdreq;
      first <= state == WAIT ? 1'b1 : push ? 1'b0 : first;
      if (state == HDR) begin
        len_lo <= hdr_len[2:0];
        words <= len2words(hdr_len);
        remaining <= len2words(hdr_len);
      end
      if (stream_pop || drop_pop || (state == IPG && remaining != '0)) remaining <= remaining - REM_W'(1);
`ifdef GIGETX_IPG_EN
      if (frame_done) remaining <= REM_W'(IPG_CYCLES - 1);
`endif
    end
endmodule

// File: tb/tb_gigetx_fifo_reader.sv
// tb_gigetx_fifo_reader: FIFO model plus output scoreboard for gigetx_fifo_reader; honours GIGETX_IPG_EN.
module tb_gigetx_fifo_reader;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
  } w_t;
  typedef struct {
    logic [15:0] len;
    bit          tog;
    int          done;
    int          err;
  } vec_t;
  logic clk = 0, reset = 1, tx_ready = 1;
  logic fifo_rdreq, fifo_empty = 1;
  logic [63:0] fifo_q = '0;
  logic [8:0] fifo_usedw = '0;
  logic [63:0] tx_data;
  logic [7:0] tx_be;
  logic tx_sop, tx_eop, tx_valid, frame_done, frame_err, busy;
  logic [63:0] fq[$];
  w_t exp_q[$];
  w_t ex;
  vec_t tbl[9];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, err_cnt = 0, underrun = 0, unstable = 0, valid_cnt = 0;
  int sop_cyc = 0, eop_cyc = 0, gap = -1, d0, e0, v0, n;
  bit gap_arm = 0, held = 0;
  logic [73:0] prev;

  always #5 clk = ~clk;

  gigetx_fifo_reader dut (
    .clk(clk), .reset(reset), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_usedw(fifo_usedw), .tx_data(tx_data), .tx_be(tx_be), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // non-showahead FIFO: q updates the cycle after rdreq; status reflects pops immediately
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      if (fq.size() == 0) underrun++;
      else fifo_q <= fq.pop_front();
    end
    fifo_usedw <= 9'(fq.size());
    fifo_empty <= fq.size() == 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (fifo_rdreq && fifo_empty) underrun++;
    if (fifo_rdreq && gap_arm) begin
      gap = cyc - eop_cyc;
      gap_arm = 0;
    end
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (tx_valid) valid_cnt++;
    if (held && !reset && (!tx_valid || {tx_data, tx_be, tx_sop, tx_eop} != prev)) unstable++;
    held = tx_valid && !tx_ready && !reset;
    prev = {tx_data, tx_be, tx_sop, tx_eop};
    if (tx_valid && tx_ready && !reset) begin
      if (exp_q.size() == 0) chk("extra_word", {tx_data, tx_be, tx_sop, tx_eop}, 0);
      else begin
        ex = exp_q.pop_front();
        chk("word", {tx_data, tx_be, tx_sop, tx_eop}, ex);
      end
      if (tx_sop) sop_cyc = cyc;
      if (tx_eop) begin
        eop_cyc = cyc;
        gap_arm = 1;
      end
    end
  end

  task automatic put(input logic [15:0] len, input int from, input int to);
    w_t e;
    logic [63:0] d;
    logic [7:0] m;
    int w;
    w = (int'(len) + 7) / 8;
    m = 8'hFF;
    if (len % 8 != 0) begin
      m = '0;
      for (int b = 0; b < int'(len % 8); b++) m[b] = 1'b1;
    end
    if (from == 0) fq.push_back({$urandom(), 16'($urandom()), len});
    for (int i = from; i < to; i++) begin
      d = {$urandom(), $urandom()};
      fq.push_back(d);
      if (len != 0 && len <= 1518) begin
        e.d = d;
        e.sop = i == 0;
        e.eop = i == w - 1;
        e.be = e.eop ? m : 8'hFF;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input bit tog);
    int k = 0;
    while ((busy || tx_valid || fq.size() != 0 || exp_q.size() != 0) && k < 4000) begin
      @(posedge clk);
      #1;
      if (tog) tx_ready = ~tx_ready;
      k++;
    end
    tx_ready = 1;
    chk("idle_timeout", k >= 4000, 0);
  endtask

  initial begin
    tbl = '{'{16'd64, 1'b0, 1, 0}, '{16'd61, 1'b0, 1, 0}, '{16'd1, 1'b0, 1, 0},
            '{16'd8, 1'b0, 1, 0}, '{16'd9, 1'b0, 1, 0}, '{16'd0, 1'b0, 0, 1},
            '{16'd160, 1'b1, 1, 0}, '{16'd1518, 1'b0, 1, 0}, '{16'd1519, 1'b0, 0, 1}};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_flags", {tx_sop, tx_eop, frame_done, frame_err}, 0);
    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      put(tbl[k].len, 0, (int'(tbl[k].len) + 7) / 8);
      wait_idle(tbl[k].tog);
      chk("done_pulses", done_cnt - d0, tbl[k].done);
      chk("err_pulses", err_cnt - e0, tbl[k].err);
      if (tbl[k].done == 1 && !tbl[k].tog) chk("contiguous", eop_cyc - sop_cyc, (int'(tbl[k].len) + 7) / 8 - 1);
    end
    // header present but only 5 of 13 words: must hold in WAIT
    d0 = done_cnt;
    v0 = valid_cnt;
    put(16'd100, 0, 5);
    repeat (30) @(posedge clk);
    #1;
    chk("wait_no_valid", valid_cnt - v0, 0);
    chk("wait_busy", busy, 1);
    put(16'd100, 5, 13);
    wait_idle(0);
    chk("wait_contig", eop_cyc - sop_cyc, 12);
    chk("wait_done", done_cnt - d0, 1);
    // oversize header drains its 250 words, next frame intact
    d0 = done_cnt;
    e0 = err_cnt;
    put(16'd2000, 0, 250);
    put(16'd64, 0, 8);
    wait_idle(0);
    chk("drop_err", err_cnt - e0, 1);
    chk("drop_next_done", done_cnt - d0, 1);
    // gap from eop acceptance to next header pop
    gap = -1;
    put(16'd16, 0, 2);
    put(16'd16, 0, 2);
    wait_idle(0);
`ifdef GIGETX_IPG_EN
    chk("ipg_gap", gap, 3);
`else
    chk("ipg_gap", gap, 1);
`endif
    // synchronous reset mid-STREAM
    put(16'd160, 0, 20);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reach_stream", n >= 50, 0);
    @(posedge clk);
    #1;
    reset = 1;
    fq.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rdreq_in_reset", fifo_rdreq, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_outputs", {tx_valid, tx_sop, tx_eop, tx_be, tx_data, frame_done, frame_err, fifo_rdreq}, 0);
    chk("mid_rst_busy", busy, 0);
    d0 = done_cnt;
    put(16'd24, 0, 3);
    wait_idle(0);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("no_underrun", underrun, 0);
    chk("stable_stall", unstable, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
